uc_arbiter: RTL and testbench
=============================

// Module: uc_arbiter
// PURPOSE
//  Unit Clause Arbiter (uca): collects unit-clause literals from NUM_ENG process engines and forwards one literal per cycle
//  to the downstream Unit Clause Queue (ucq) via its push/uca2ucq/full interface. Round-robin fair among engines.
//  Tracks an assignment table: drops duplicate literals and detects conflicts (both polarities of one variable).
// PARAMETERS
//  NUM_ENG    4    number of engine request ports
//  UC_LENGTH  512  literal space; LIT_W = $clog2(UC_LENGTH) = 9
//  NUM_VAR    UC_LENGTH/2  variables; lit = {var[LIT_W-2:0], pol}; pol=1 means the positive literal
// PORTS
//  clk           in   1                clock
//  rst           in   1                synchronous, active-high reset
//  eng_valid     in   NUM_ENG          engine i presents a literal
//  eng_lit       in   NUM_ENG x LIT_W  literal from engine i
//  eng_ready     out  NUM_ENG          literal i consumed this cycle (one-hot or zero)
//  ucq_full      in   1                ucq full; no push allowed
//  ucq_push      out  1                push to ucq
//  uca2ucq       out  LIT_W            literal pushed, valid with ucq_push
//  clear         in   1                start table clear (backtrack/new problem)
//  busy          out  1                clear sweep in progress
//  conflict      out  1                sticky conflict flag
//  conflict_lit  out  LIT_W            literal that caused the conflict
//  push_cnt      out  16               literals pushed since reset/clear, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state=RUN; rr_ptr=0; table all unassigned; conflict=0; conflict_lit=0; push_cnt=0; busy=0; all outputs low.
//  FSM: RUN, CONFLICT, CLEAR.
//   RUN: grant = first valid engine at or after rr_ptr (wrapping); grant only when !ucq_full.
//    Lookup table[var(lit)]:
//     unassigned -> ucq_push=1, uca2ucq=lit, eng_ready[g]=1; table gets {assigned=1, val=pol} at next edge; push_cnt++.
//     assigned, same pol -> duplicate: eng_ready[g]=1, no push.
//     assigned, opposite pol -> eng_ready[g]=1, no push; conflict<=1, conflict_lit<=lit; next state CONFLICT.
//    ucq_full=1 -> no grant, no ready; the table and rr_ptr hold. Duplicates also wait while full (grant is gated first).
//    rr_ptr <= (g+1) mod NUM_ENG after any grant; unchanged otherwise.
//   CONFLICT: eng_ready=0, ucq_push=0; hold until clear.
//   clear (any state, priority over grant in that cycle): no grant that cycle; next state CLEAR;
//    sweep counter=0; busy=1.
//   CLEAR: one table entry zeroed per cycle, counter 0..NUM_VAR-1; eng_ready=0, ucq_push=0.
//    After the last entry: conflict=0, push_cnt=0, rr_ptr=0, state RUN, busy=0 on the next cycle. clear asserted during CLEAR restarts the sweep at 0.
//  Latency: push is combinational from eng_valid within the same cycle; the table update is visible the next cycle.
//   Back-to-back same literal from two engines in consecutive cycles: the second is a duplicate.
//  Only one grant per cycle, so there is no intra-cycle table hazard. ucq_push is never asserted with ucq_full=1.
//  Engines hold eng_valid/eng_lit stable until eng_ready.
//  rst mid-CLEAR or mid-CONFLICT: immediate return to reset state.
// STRUCTURE
//  Package uc_pkg: UC_LENGTH, LIT_W, NUM_VAR, typedef lit_t, typedef struct packed {logic asg; logic val;} var_ent_t,
//   enum uca_state_e {RUN, CONFLICT, CLEAR}; shared with uc_queue.
//  Sub-module rr_arbiter #(N) (req, en, gnt onehot, gnt_idx, ptr update) is natural; the table is an in-module flop array.
// TESTING (NUM_ENG=4)
//  1. Reset, eng0 lit 9'h006 -> same-cycle ucq_push=1, uca2ucq=9'h006, eng_ready=4'b0001, push_cnt=1.
//  2. All 4 valid, distinct lits 2,4,6,8, ucq never full -> pushes in order eng0,1,2,3 over 4 cycles; rr wraps to eng0.
//  3. eng1 sends 9'h00B, then eng2 sends 9'h00B -> second is consumed with no push; push_cnt stays 1.
//  4. Push 9'h00B, then 9'h00A -> conflict=1, conflict_lit=9'h00A; later valids get no ready or push until clear.
//  5. ucq_full=1 with eng3 valid for 3 cycles -> no push/ready; full drops -> push on that cycle.
//  6. Clear after conflict -> busy=1 for 256 cycles; then lit 9'h00A is pushed, conflict=0, push_cnt=1.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the unit-clause path: literal encoding, the
// per-variable assignment entry and the arbiter state encoding.
package uc_pkg;

    localparam int UC_LENGTH = 512;
    localparam int LIT_W     = $clog2(UC_LENGTH);
    localparam int NUM_VAR   = UC_LENGTH / 2;
    localparam int VAR_W     = LIT_W - 1;

    // A literal is {variable index, polarity}; polarity 1 is the positive literal.
    typedef logic [LIT_W-1:0] lit_t;
    typedef logic [VAR_W-1:0] var_idx_t;

    // One assignment-table entry: whether the variable is set, and to which value.
    typedef struct packed {
        logic asg;
        logic val;
    } var_ent_t;

    typedef enum logic [1:0] {
        RUN,
        CONFLICT,
        CLEAR
    } uca_state_e;

    // Variable index carried by a literal.
    function automatic var_idx_t lit_var(input lit_t lit);
        return lit[LIT_W-1:1];
    endfunction

    // Polarity carried by a literal.
    function automatic logic lit_pol(input lit_t lit);
        return lit[0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping, and moves the pointer one past the winner after each grant.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             ptr_clr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] ptr;

    // Pick the first requester starting from ptr, wrapping around.
    always_comb begin : p_pick
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default before the search loop so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (en && !gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Advance the pointer past the winner; clear it on reset or end of table sweep.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst || ptr_clr) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: forwards one engine literal per cycle to the unit
// clause queue, filtering duplicates against an assignment table and
// flagging conflicts (both polarities of one variable).
module uc_arbiter
    import uc_pkg::*;
#(
    parameter  int NUM_ENG = 4,
    localparam int IDX_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_ENG-1:0]       eng_valid,
    input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
    output logic [NUM_ENG-1:0]       eng_ready,
    input  logic                     ucq_full,
    output logic                     ucq_push,
    output logic [LIT_W-1:0]         uca2ucq,
    input  logic                     clear,
    output logic                     busy,
    output logic                     conflict,
    output logic [LIT_W-1:0]         conflict_lit,
    output logic [15:0]              push_cnt
);

    uca_state_e       state;
    var_idx_t         sweep_cnt;
    var_ent_t         tbl [NUM_VAR];

    logic             arb_en;
    logic             sweep_done;
    logic [NUM_ENG-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    lit_t             g_lit;
    var_ent_t         g_ent;
    logic             lit_new;
    logic             lit_conf;

    // Grants only happen in RUN, outside reset, with room downstream and no clear pending.
    assign arb_en     = !rst && (state == RUN) && !clear && !ucq_full;
    assign sweep_done = (state == CLEAR) && !clear && (sweep_cnt == VAR_W'(NUM_VAR - 1));

    rr_arbiter #(.N(NUM_ENG)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (eng_valid),
        .en        (arb_en),
        .ptr_clr   (sweep_done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Select the granted engine's literal.
    always_comb begin
        g_lit = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                g_lit = eng_lit[i*LIT_W +: LIT_W];
            end
        end
    end

    // Classify the granted literal against the table: new, duplicate or conflicting.
    assign g_ent    = tbl[lit_var(g_lit)];
    assign lit_new  = gnt_valid && !g_ent.asg;
    assign lit_conf = gnt_valid && g_ent.asg && (g_ent.val != lit_pol(g_lit));

    // Duplicates and conflicts are consumed too; only new literals are pushed.
    assign eng_ready = gnt;
    assign ucq_push  = lit_new;
    assign uca2ucq   = lit_new ? g_lit : '0;

    // Control FSM: conflict capture, push counting and the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            sweep_cnt    <= '0;
            busy         <= 1'b0;
            conflict     <= 1'b0;
            conflict_lit <= '0;
            push_cnt     <= '0;
        end else if (clear) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (lit_new && (push_cnt != 16'hFFFF)) begin
                        push_cnt <= push_cnt + 16'd1;
                    end
                    if (lit_conf) begin
                        conflict     <= 1'b1;
                        conflict_lit <= g_lit;
                        state        <= CONFLICT;
                    end
                end
                CONFLICT: begin
                    state <= CONFLICT;
                end
                CLEAR: begin
                    if (sweep_done) begin
                        state    <= RUN;
                        busy     <= 1'b0;
                        conflict <= 1'b0;
                        push_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Assignment table: record new literals, zero one entry per cycle while clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this table is a flop array whose contents decide correctness
            // right after reset, so it is reset explicitly; a RAM could not be.
            for (int i = 0; i < NUM_VAR; i++) begin
                tbl[i] <= '0;
            end
        end else if (state == CLEAR) begin
            tbl[sweep_cnt] <= '0;
        end else if (lit_new) begin
            tbl[lit_var(g_lit)] <= '{asg: 1'b1, val: lit_pol(g_lit)};
        end
    end

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: a behavioural model predicts each
// cycle's outputs into a scoreboard queue, which is popped and compared
// against the DUT mid-cycle.
module tb_uc_arbiter;

    localparam int M_RUN  = 0;
    localparam int M_CONF = 1;
    localparam int M_CLR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  eng_valid;
    logic [35:0] eng_lit;
    logic [3:0]  eng_ready;
    logic        ucq_full;
    logic        ucq_push;
    logic [8:0]  uca2ucq;
    logic        clear;
    logic        busy;
    logic        conflict;
    logic [8:0]  conflict_lit;
    logic [15:0] push_cnt;

    uc_arbiter #(.NUM_ENG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .eng_valid    (eng_valid),
        .eng_lit      (eng_lit),
        .eng_ready    (eng_ready),
        .ucq_full     (ucq_full),
        .ucq_push     (ucq_push),
        .uca2ucq      (uca2ucq),
        .clear        (clear),
        .busy         (busy),
        .conflict     (conflict),
        .conflict_lit (conflict_lit),
        .push_cnt     (push_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ready;
        logic        push;
        logic [8:0]  lit;
        logic        conf;
        logic [8:0]  clit;
        logic [15:0] pcnt;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit          m_asg [256];
    bit          m_val [256];
    int          m_ptr;
    int          m_state;
    int          m_cnt;
    logic        m_conf;
    logic [8:0]  m_clit;
    logic [15:0] m_pc;
    logic        m_busy;

    // Engine literals, packed onto eng_lit each step
    logic [8:0]  lit_arr [4];

    // Observed outputs of the most recent step
    logic [3:0]  obs_ready;
    logic        obs_push;
    logic [8:0]  obs_lit;
    logic        obs_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_asg   = '{default: 1'b0};
        m_val   = '{default: 1'b0};
        m_ptr   = 0;
        m_state = M_RUN;
        m_cnt   = 0;
        m_conf  = 1'b0;
        m_clit  = '0;
        m_pc    = '0;
        m_busy  = 1'b0;
    endtask

    // Hold reset for two edges with all engines requesting; outputs must stay low.
    task automatic do_reset();
        rst       = 1'b1;
        clear     = 1'b0;
        ucq_full  = 1'b0;
        eng_valid = 4'b1111;
        eng_lit   = {lit_arr[3], lit_arr[2], lit_arr[1], lit_arr[0]};
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(eng_ready), 32'h0);
        check("rst_push", 32'(ucq_push), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_conflict", 32'(conflict), 32'h0);
        check("rst_clit", 32'(conflict_lit), 32'h0);
        check("rst_cnt", 32'(push_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        eng_valid = 4'b0000;
        model_reset();
    endtask

    // One clock cycle: drive, predict into the scoreboard, compare mid-cycle, advance model.
    task automatic step(input logic [3:0] v, input logic full, input logic clr);
        exp_t       e;
        int         g;
        logic [7:0] vi;
        logic       p;
        eng_valid = v;
        eng_lit   = {lit_arr[3], lit_arr[2], lit_arr[1], lit_arr[0]};
        ucq_full  = full;
        clear     = clr;
        g  = -1;
        vi = '0;
        p  = 1'b0;
        e.ready = '0;
        e.push  = 1'b0;
        e.lit   = '0;
        e.conf  = m_conf;
        e.clit  = m_clit;
        e.pcnt  = m_pc;
        e.busy  = m_busy;
        if (m_state == M_RUN && !clr && !full) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            e.ready[g] = 1'b1;
            vi = lit_arr[g][8:1];
            p  = lit_arr[g][0];
            if (!m_asg[vi]) begin
                e.push = 1'b1;
                e.lit  = lit_arr[g];
            end
        end
        sb.push_back(e);

        @(negedge clk);
        obs_ready = eng_ready;
        obs_push  = ucq_push;
        obs_lit   = uca2ucq;
        obs_busy  = busy;
        e = sb.pop_front();
        check("sb_ready", 32'(obs_ready), 32'(e.ready));
        check("sb_push", 32'(obs_push), 32'(e.push));
        if (e.push) check("sb_lit", 32'(obs_lit), 32'(e.lit));
        check("sb_conflict", 32'(conflict), 32'(e.conf));
        if (e.conf) check("sb_clit", 32'(conflict_lit), 32'(e.clit));
        check("sb_cnt", 32'(push_cnt), 32'(e.pcnt));
        check("sb_busy", 32'(obs_busy), 32'(e.busy));

        @(posedge clk);
        if (clr) begin
            m_state = M_CLR;
            m_cnt   = 0;
            m_busy  = 1'b1;
        end else if (m_state == M_RUN) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % 4;
                if (!m_asg[vi]) begin
                    m_asg[vi] = 1'b1;
                    m_val[vi] = p;
                    if (m_pc != 16'hFFFF) m_pc = m_pc + 16'd1;
                end else if (m_val[vi] != p) begin
                    m_conf  = 1'b1;
                    m_clit  = lit_arr[g];
                    m_state = M_CONF;
                end
            end
        end else if (m_state == M_CLR) begin
            m_asg[m_cnt] = 1'b0;
            m_val[m_cnt] = 1'b0;
            if (m_cnt == 255) begin
                m_state = M_RUN;
                m_busy  = 1'b0;
                m_conf  = 1'b0;
                m_pc    = '0;
                m_ptr   = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
    endtask

    // Idle until busy drops, returning how many cycles it was seen high (bounded).
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            step(4'b0000, 1'b0, 1'b0);
            if (obs_busy) n++;
            else break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] mask;
        for (int i = 0; i < 4; i++) lit_arr[i] = '0;
        model_reset();

        // 1. single literal from eng0 after reset
        do_reset();
        lit_arr[0] = 9'h006;
        step(4'b0001, 1'b0, 1'b0);
        check("t1_push", 32'(obs_push), 32'h1);
        check("t1_lit", 32'(obs_lit), 32'h006);
        check("t1_ready", 32'(obs_ready), 32'b0001);
        check("t1_cnt", 32'(push_cnt), 32'h1);

        // 2. all four engines, round-robin order then wrap to eng0
        do_reset();
        lit_arr[0] = 9'h002;
        lit_arr[1] = 9'h004;
        lit_arr[2] = 9'h006;
        lit_arr[3] = 9'h008;
        mask = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step(mask, 1'b0, 1'b0);
            check($sformatf("t2_ready%0d", k), 32'(obs_ready), 32'(1 << k));
            check($sformatf("t2_push%0d", k), 32'(obs_push), 32'h1);
            mask[k] = 1'b0;
        end
        lit_arr[0] = 9'h020;
        lit_arr[3] = 9'h022;
        step(4'b1001, 1'b0, 1'b0);
        check("t2_wrap", 32'(obs_ready), 32'b0001);
        check("t2_cnt", 32'(push_cnt), 32'h5);

        // 3. same literal from two engines in consecutive cycles
        do_reset();
        lit_arr[1] = 9'h00B;
        step(4'b0010, 1'b0, 1'b0);
        lit_arr[2] = 9'h00B;
        step(4'b0100, 1'b0, 1'b0);
        check("t3_dup_push", 32'(obs_push), 32'h0);
        check("t3_dup_ready", 32'(obs_ready), 32'b0100);
        check("t3_cnt", 32'(push_cnt), 32'h1);

        // 4. opposite polarity -> conflict, then everything blocked
        lit_arr[0] = 9'h00A;
        step(4'b0001, 1'b0, 1'b0);
        check("t4_push", 32'(obs_push), 32'h0);
        check("t4_ready", 32'(obs_ready), 32'b0001);
        check("t4_conflict", 32'(conflict), 32'h1);
        check("t4_clit", 32'(conflict_lit), 32'h00A);
        for (int i = 0; i < 4; i++) lit_arr[i] = 9'(9'h040 + 2 * i);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 1'b0, 1'b0);
            check("t4_blk_ready", 32'(obs_ready), 32'h0);
            check("t4_blk_push", 32'(obs_push), 32'h0);
        end

        // 6. clear after conflict: 256 busy cycles, then a fresh push
        step(4'b0000, 1'b0, 1'b1);
        count_busy(n);
        check("t6_busy_len", 32'(n), 32'd256);
        check("t6_conflict", 32'(conflict), 32'h0);
        lit_arr[0] = 9'h00A;
        step(4'b0001, 1'b0, 1'b0);
        check("t6_push", 32'(obs_push), 32'h1);
        check("t6_lit", 32'(obs_lit), 32'h00A);
        check("t6_cnt", 32'(push_cnt), 32'h1);

        // 5. ucq_full holds off eng3 for three cycles
        lit_arr[3] = 9'h030;
        for (int k = 0; k < 3; k++) begin
            step(4'b1000, 1'b1, 1'b0);
            check("t5_full_push", 32'(obs_push), 32'h0);
            check("t5_full_ready", 32'(obs_ready), 32'h0);
        end
        step(4'b1000, 1'b0, 1'b0);
        check("t5_push", 32'(obs_push), 32'h1);
        check("t5_ready", 32'(obs_ready), 32'b1000);

        // clear re-asserted mid-sweep restarts it
        step(4'b0000, 1'b0, 1'b1);
        repeat (10) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        count_busy(n);
        check("restart_len", 32'(n), 32'd256);

        // reset in the middle of a sweep returns to the reset state
        lit_arr[1] = 9'h030;
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        check("midclr_push", 32'(obs_push), 32'h1);
        check("midclr_ready", 32'(obs_ready), 32'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
